// File: rtl/sprite_palette_ctrl.sv
// Banked RGB palette with a 2-stage lookup pipeline and a frame-stepped
// brightness fade applied to every lookup result.
module sprite_palette_ctrl #(
    parameter int INDEX_W    = 4,
    parameter int CHAN_W     = 4,
    parameter int BANKS      = 2,
    parameter int TRANSP_IDX = 0,
    localparam int BANK_W    = (BANKS > 1) ? $clog2(BANKS) : 1,
    localparam int LVL_MAX   = 2 ** CHAN_W
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  valid_in,
    input  logic [INDEX_W-1:0]    index,
    input  logic [BANK_W-1:0]     bank,
    input  logic                  wr_en,
    input  logic [BANK_W-1:0]     wr_bank,
    input  logic [INDEX_W-1:0]    wr_addr,
    input  logic [3*CHAN_W-1:0]   wr_data,
    input  logic [1:0]            fade_cmd,
    input  logic                  frame_tick,
    output logic                  valid_out,
    output logic [CHAN_W-1:0]     red,
    output logic [CHAN_W-1:0]     green,
    output logic [CHAN_W-1:0]     blue,
    output logic                  transparent,
    output logic                  fade_busy,
    output logic [CHAN_W:0]       fade_level
);

    localparam int DEPTH   = 2 ** INDEX_W;
    localparam int ENTRY_W = 3 * CHAN_W;
    localparam logic [CHAN_W:0] LVL_TOP = (CHAN_W+1)'(LVL_MAX);
    localparam logic [CHAN_W:0] LVL_ONE = (CHAN_W+1)'(1);

    typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} fade_state_t;

    fade_state_t          state_reg, state_next;
    logic [CHAN_W:0]      level_reg, level_next;

    logic [ENTRY_W-1:0]   pal_reg [BANKS][DEPTH];
    logic [ENTRY_W-1:0]   s1_entry_reg;
    logic                 s1_valid_reg;
    logic                 s1_transp_reg;
    logic [CHAN_W-1:0]    scaled [3];

    // Palette storage; lookups read the pre-write contents on a collision.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int b = 0; b < BANKS; b++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    pal_reg[b][e] <= (e == TRANSP_IDX) ? '1 : '0;
                end
            end
        end else if (wr_en && (int'(wr_bank) < BANKS)) begin
            pal_reg[wr_bank][wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            s1_entry_reg  <= '0;
            s1_valid_reg  <= 1'b0;
            s1_transp_reg <= 1'b0;
        end else begin
            s1_entry_reg  <= (int'(bank) < BANKS) ? pal_reg[bank][index] : '0;
            s1_valid_reg  <= valid_in;
            s1_transp_reg <= (index == INDEX_W'(TRANSP_IDX));
        end
    end

    // Channel 0 is blue, 2 is red; the product never exceeds 2*CHAN_W bits.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [2*CHAN_W-1:0] prod;
            assign prod = (2*CHAN_W)'(s1_entry_reg[gi*CHAN_W +: CHAN_W])
                        * (2*CHAN_W)'(level_reg);
            assign scaled[gi] = prod[2*CHAN_W-1:CHAN_W];
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            valid_out   <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            transparent <= 1'b0;
        end else begin
            valid_out <= s1_valid_reg;
            if (s1_valid_reg) begin
                red         <= scaled[2];
                green       <= scaled[1];
                blue        <= scaled[0];
                transparent <= s1_transp_reg;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_reg <= IDLE;
            level_reg <= LVL_TOP;
        end else begin
            state_reg <= state_next;
            level_reg <= level_next;
        end
    end

    // A fade already at its end level still occupies one tick before idling.
    always_comb begin
        state_next = state_reg;
        level_next = level_reg;
        case (state_reg)
            IDLE: begin
                if (fade_cmd == 2'b01) begin
                    state_next = FADE_OUT;
                end else if (fade_cmd == 2'b10) begin
                    state_next = FADE_IN;
                end
            end
            FADE_OUT: begin
                if (frame_tick) begin
                    if (level_reg != '0) begin
                        level_next = level_reg - LVL_ONE;
                    end
                    if (level_reg <= LVL_ONE) begin
                        state_next = IDLE;
                    end
                end
            end
            FADE_IN: begin
                if (frame_tick) begin
                    if (level_reg != LVL_TOP) begin
                        level_next = level_reg + LVL_ONE;
                    end
                    if (level_reg >= LVL_TOP - LVL_ONE) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign fade_busy  = (state_reg != IDLE);
    assign fade_level = level_reg;

endmodule

// File: tb/tb_sprite_palette_ctrl.sv
// Scoreboard bench for sprite_palette_ctrl: directed scenarios then random
// traffic, checked against an integer-arithmetic palette/fade model.
module tb_sprite_palette_ctrl;

    localparam int NB = 3;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        valid_in;
    logic [3:0]  index;
    logic [1:0]  bank;
    logic        wr_en;
    logic [1:0]  wr_bank;
    logic [3:0]  wr_addr;
    logic [11:0] wr_data;
    logic [1:0]  fade_cmd;
    logic        frame_tick;
    logic        valid_out;
    logic [3:0]  red, green, blue;
    logic        transparent;
    logic        fade_busy;
    logic [4:0]  fade_level;

    sprite_palette_ctrl #(
        .INDEX_W(4), .CHAN_W(4), .BANKS(NB), .TRANSP_IDX(0)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .valid_in(valid_in), .index(index),
        .bank(bank), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .wr_data(wr_data), .fade_cmd(fade_cmd), .frame_tick(frame_tick),
        .valid_out(valid_out), .red(red), .green(green), .blue(blue),
        .transparent(transparent), .fade_busy(fade_busy), .fade_level(fade_level)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int r;
        int g;
        int b;
        int t;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    int   mdl_mem [NB][16];
    int   mdl_level;
    int   mdl_mode;      // 0 idle, 1 fading out, 2 fading in
    int   prev_valid;
    int   exp_vo;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Apply the effect of the clock edge that just sampled the current inputs.
    task automatic model_apply();
        int   entry;
        exp_t e;
        if (!Reset_n) begin
            for (int b = 0; b < NB; b++)
                for (int i = 0; i < 16; i++)
                    mdl_mem[b][i] = (i == 0) ? 12'hFFF : 0;
            mdl_level  = 16;
            mdl_mode   = 0;
            prev_valid = 0;
            exp_vo     = 0;
            exp_q.delete();
            return;
        end
        exp_vo     = prev_valid;
        prev_valid = int'(valid_in);
        entry = (int'(bank) < NB) ? mdl_mem[bank][index] : 0;
        if (wr_en && int'(wr_bank) < NB)
            mdl_mem[wr_bank][wr_addr] = int'(wr_data);
        if (mdl_mode == 0) begin
            if (fade_cmd == 2'b01) mdl_mode = 1;
            else if (fade_cmd == 2'b10) mdl_mode = 2;
        end else if (frame_tick) begin
            if (mdl_mode == 1) begin
                if (mdl_level > 0) mdl_level--;
                if (mdl_level == 0) mdl_mode = 0;
            end else begin
                if (mdl_level < 16) mdl_level++;
                if (mdl_level == 16) mdl_mode = 0;
            end
        end
        if (valid_in) begin
            e.r = ((entry / 256) % 16) * mdl_level / 16;
            e.g = ((entry / 16) % 16) * mdl_level / 16;
            e.b = (entry % 16) * mdl_level / 16;
            e.t = (index == 4'd0) ? 1 : 0;
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        model_apply();
        chk("fade_level", int'(fade_level), mdl_level);
        chk("fade_busy", int'(fade_busy), (mdl_mode != 0) ? 1 : 0);
        chk("valid_out", int'(valid_out), exp_vo);
    endtask

    task automatic idle_inputs();
        valid_in = 0; wr_en = 0; fade_cmd = 2'b00; frame_tick = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset_n = 0;
        tick();
        tick();
        chk("rst_rgb", int'({red, green, blue}), 0);
        chk("rst_transparent", int'(transparent), 0);
        chk("rst_valid_out", int'(valid_out), 0);
        Reset_n = 1;
    endtask

    task automatic lookup(input int b, input int i);
        valid_in = 1; bank = 2'(b); index = 4'(i);
        tick();
        valid_in = 0;
    endtask

    task automatic write(input int b, input int a, input int d);
        wr_en = 1; wr_bank = 2'(b); wr_addr = 4'(a); wr_data = 12'(d);
        tick();
        wr_en = 0;
    endtask

    task automatic ticks(input int n);
        frame_tick = 1;
        for (int k = 0; k < n; k++) tick();
        frame_tick = 0;
    endtask

    task automatic cmd(input int c);
        fade_cmd = 2'(c);
        tick();
        fade_cmd = 2'b00;
    endtask

    // Monitor: every presented result is matched against the oldest expectation.
    exp_t mon_e;
    always @(negedge Clk) begin
        if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got rgb=%h with no expected entry at %0t",
                         {red, green, blue}, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("red", int'(red), mon_e.r);
                chk("green", int'(green), mon_e.g);
                chk("blue", int'(blue), mon_e.b);
                chk("transparent", int'(transparent), mon_e.t);
            end
        end
    end

    initial begin
        bank = 0; index = 0; wr_bank = 0; wr_addr = 0; wr_data = 0;
        do_reset();

        // Reset palette contents: index 0 white and transparent, others black.
        valid_in = 1; bank = 0; index = 0;
        tick();
        index = 5;
        tick();
        valid_in = 0;
        tick(); tick();

        write(1, 3, 12'hDC7);
        lookup(1, 3);
        lookup(0, 3);
        tick(); tick();

        // Same-cycle write and read return the old contents.
        wr_en = 1; wr_bank = 0; wr_addr = 2; wr_data = 12'h5A3;
        valid_in = 1; bank = 0; index = 2;
        tick();
        wr_en = 0;
        tick();
        valid_in = 0;
        tick(); tick();

        // Out-of-range bank: writes dropped, reads black; last real bank works.
        write(3, 6, 12'h9AB);
        write(2, 6, 12'h456);
        lookup(3, 6);
        lookup(2, 6);
        tick(); tick();

        cmd(1);
        ticks(8);
        chk("level_after_8", int'(fade_level), 8);
        lookup(1, 3);
        tick(); tick();
        chk("rgb_at_level_8", int'({red, green, blue}), 12'h663);
        ticks(8);
        chk("level_after_16", int'(fade_level), 0);
        chk("busy_after_16", int'(fade_busy), 0);
        lookup(1, 3);
        tick(); tick();

        // Fade-out from 0: in-flight fade-in request ignored, one tick to idle.
        cmd(1);
        cmd(2);
        ticks(1);
        chk("level_hold_0", int'(fade_level), 0);
        cmd(2);
        ticks(16);
        lookup(1, 3);
        tick(); tick();
        chk("rgb_full", int'({red, green, blue}), 12'hDC7);

        // Reset mid-fade restores full level and clears bank 1.
        cmd(1);
        ticks(11);
        chk("level_5", int'(fade_level), 5);
        write(1, 4, 12'h123);
        do_reset();
        chk("level_after_rst", int'(fade_level), 16);
        lookup(1, 4);
        lookup(1, 3);
        tick(); tick();

        for (int n = 0; n < 3000; n++) begin
            Reset_n    = ($urandom_range(0, 149) != 0);
            valid_in   = ($urandom_range(0, 2) != 0);
            index      = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            bank       = 2'($urandom_range(0, 3));
            wr_en      = ($urandom_range(0, 3) == 0);
            wr_bank    = 2'($urandom_range(0, 3));
            wr_addr    = 4'($urandom_range(0, 15));
            wr_data    = 12'($urandom_range(0, 4095));
            fade_cmd   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            frame_tick = ($urandom_range(0, 1) == 1);
            tick();
        end
        Reset_n = 1;
        idle_inputs();
        tick(); tick(); tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
